// File: rtl/intr_arb.sv
// intr_arb: masks and latches interrupt sources, picks the lowest-index one on a valid decode slot and holds it until ertn_w.
module intr_arb #(
   parameter int NSRC = 8,
   parameter int IDW  = 3
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [NSRC-1:0] src_intr,
   input  logic            vld_d,
   input  logic            ertn_w,
   input  logic            cfg_we,
   input  logic [1:0]      cfg_addr,
   input  logic [NSRC-1:0] cfg_wdata,
   output logic [NSRC-1:0] cfg_rdata,
   output logic            intr_sync,
   output logic            intr_sync_pulse,
   output logic [IDW-1:0]  intr_id
);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t          r_state;
   logic [NSRC-1:0] r_src_q, r_mask, r_edge, r_edge_pend;
   logic            r_sync, r_pulse;
   logic [IDW-1:0]  r_id;
   logic [NSRC-1:0] w_eff, w_elig, w_win_oh, w_edge_nxt, w_set, w_clr;
   logic [IDW-1:0]  w_win;
   logic            w_take, w_wr_mask, w_wr_mode, w_wr_pend;
   assign w_eff      = (src_intr & ~r_edge) | (r_edge_pend & r_edge);
   assign w_elig     = w_eff & r_mask;
   assign w_win_oh   = w_elig & (~w_elig + 1'b1);
   assign w_take     = (r_state == IDLE) & vld_d & (|w_elig);
   assign w_wr_mask  = cfg_we & (cfg_addr == 2'd0);
   assign w_wr_mode  = cfg_we & (cfg_addr == 2'd1);
   assign w_wr_pend  = cfg_we & (cfg_addr == 2'd2);
   assign w_edge_nxt = w_wr_mode ? cfg_wdata : r_edge;
   // a new rising edge always survives a same-cycle clear
   assign w_set      = src_intr & ~r_src_q & w_edge_nxt;
   assign w_clr      = (w_take ? w_win_oh : '0) | (w_wr_pend ? cfg_wdata : '0) |
                       (w_wr_mode ? (cfg_wdata ^ r_edge) : '0);
   assign cfg_rdata  = cfg_addr == 2'd0 ? r_mask :
                       cfg_addr == 2'd1 ? r_edge :
                       cfg_addr == 2'd2 ? w_eff  : NSRC'({r_sync, r_id});
   assign intr_sync       = r_sync;
   assign intr_sync_pulse = r_pulse;
   assign intr_id         = r_id;
   always_comb begin
      w_win = '0;
      for (int i = NSRC - 1; i >= 0; i--)
         if (w_elig[i]) w_win = IDW'(i);
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_src_q     <= '0;
         r_mask      <= '0;
         r_edge      <= '0;
         r_edge_pend <= '0;
      end else begin
         r_src_q     <= src_intr;
         r_edge      <= w_edge_nxt;
         r_edge_pend <= (r_edge_pend & ~w_clr) | w_set;
         if (w_wr_mask) r_mask <= cfg_wdata;
      end
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_sync  <= 1'b0;
         r_pulse <= 1'b0;
         r_id    <= '0;
      end else if (r_state == IDLE) begin
         r_sync  <= w_take;
         r_pulse <= w_take;
         if (w_take) begin
            r_state <= ACTIVE;
            r_id    <= w_win;
         end
      end else begin
         r_pulse <= 1'b0;
         if (ertn_w) begin
            r_state <= IDLE;
            r_sync  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_intr_arb.sv
// tb_intr_arb: directed checks of take/service/return, edge pending, masking and async reset.
module tb_intr_arb;
   logic       clk, resetn, vld_d, ertn_w, cfg_we;
   logic [7:0] src_intr, cfg_wdata, cfg_rdata;
   logic [1:0] cfg_addr;
   logic       intr_sync, intr_sync_pulse;
   logic [2:0] intr_id;
   int n_pass = 0, n_total = 0;

   intr_arb #(.NSRC(8), .IDW(3)) dut (
      .clk(clk), .resetn(resetn), .src_intr(src_intr), .vld_d(vld_d), .ertn_w(ertn_w),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
      .intr_sync(intr_sync), .intr_sync_pulse(intr_sync_pulse), .intr_id(intr_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_we = 1'b0; cfg_wdata = '0;
   endtask

   task automatic chk_out(input string tag, input logic s, input logic p, input logic [2:0] id);
      chk({tag, ".sync"}, intr_sync, s);
      chk({tag, ".pulse"}, intr_sync_pulse, p);
      chk({tag, ".id"}, intr_id, id);
   endtask

   task automatic chk_rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
      cfg_addr = a;
      #1;
      chk(tag, cfg_rdata, exp);
   endtask

   initial begin
      resetn = 1'b0; vld_d = 0; ertn_w = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; src_intr = 0;
      tick(); tick();
      chk_out("reset", 0, 0, 0);
      chk_rd("reset.mask", 2'd0, 8'h00);
      chk_rd("reset.mode", 2'd1, 8'h00);
      chk_rd("reset.pend", 2'd2, 8'h00);
      chk_rd("reset.stat", 2'd3, 8'h00);
      resetn = 1'b1;
      tick();

      // level source 5: take, pulse, return, retake
      cfg_write(2'd0, 8'hFF);
      src_intr = 8'h20; vld_d = 1;
      tick();                                  chk_out("l5.take", 1, 1, 3'd5);
      chk_rd("l5.stat", 2'd3, 8'h0D);
      tick();                                  chk_out("l5.t2", 1, 0, 3'd5);
      tick();
      ertn_w = 1; tick();                      chk("l5.ertn.sync", intr_sync, 1'b0);
      ertn_w = 0; tick();                      chk_out("l5.retake", 1, 1, 3'd5);
      ertn_w = 1; src_intr = 0; tick();        chk("l5.exit", intr_sync, 1'b0);
      ertn_w = 0;

      // priority: 2 before 6
      src_intr = 8'h44; tick();                chk_out("pri.2", 1, 1, 3'd2);
      ertn_w = 1; src_intr = 8'h40; tick();    chk("pri.exit", intr_sync, 1'b0);
      ertn_w = 0; tick();                      chk_out("pri.6", 1, 1, 3'd6);
      ertn_w = 1; src_intr = 0; tick();        chk("pri.exit2", intr_sync, 1'b0);
      ertn_w = 0;

      // edge source 3
      vld_d = 0;
      cfg_write(2'd1, 8'h08);
      src_intr = 8'h08; tick();
      src_intr = 8'h00; tick();
      tick(); tick(); tick(); tick();
      chk_rd("e3.pend.held", 2'd2, 8'h08);
      chk("e3.idle", intr_sync, 1'b0);
      vld_d = 1; tick();                       chk_out("e3.take", 1, 1, 3'd3);
      chk_rd("e3.pend.clr", 2'd2, 8'h00);
      src_intr = 8'h08; tick();
      src_intr = 8'h00; tick();
      chk_rd("e3.pend.again", 2'd2, 8'h08);
      chk_out("e3.nonest", 1, 0, 3'd3);
      ertn_w = 1; tick();                      chk("e3.exit", intr_sync, 1'b0);
      chk_rd("e3.pend.kept", 2'd2, 8'h08);
      ertn_w = 0; tick();                      chk_out("e3.retake", 1, 1, 3'd3);
      chk_rd("e3.pend.clr2", 2'd2, 8'h00);
      ertn_w = 1; tick();
      ertn_w = 0;
      cfg_write(2'd1, 8'h00);

      // masking
      cfg_write(2'd0, 8'h00);
      src_intr = 8'hFF; tick(); tick();        chk("mask0.sync", intr_sync, 1'b0);
      cfg_write(2'd0, 8'h10);                  chk("mask10.wr", intr_sync, 1'b0);
      tick();                                  chk_out("mask10.take", 1, 1, 3'd4);
      cfg_write(2'd0, 8'hFF);                  chk_out("mask.active", 1, 0, 3'd4);

      // ertn with vld_d and eligible source: no take that cycle
      src_intr = 8'h02; ertn_w = 1; tick();    chk_out("sim.ertn", 0, 0, 3'd4);
      ertn_w = 0; tick();                      chk_out("sim.take", 1, 1, 3'd1);
      ertn_w = 1; tick();                      chk_out("sim.oneshot", 0, 0, 3'd1);
      ertn_w = 0; src_intr = 0;

      // async reset mid-service with an edge pending
      cfg_write(2'd1, 8'h01);
      src_intr = 8'h80; tick();                chk_out("rst.take7", 1, 1, 3'd7);
      src_intr = 8'h81; tick();
      src_intr = 8'h80; tick();
      src_intr = 8'h00; tick();
      chk_rd("rst.pend.pre", 2'd2, 8'h01);
      chk("rst.leveldrop", intr_sync, 1'b1);
      resetn = 1'b0;
      #1;
      chk_out("rst.async", 0, 0, 3'd0);
      chk_rd("rst.pend", 2'd2, 8'h00);
      tick();
      resetn = 1'b1;
      cfg_write(2'd0, 8'hFF);
      cfg_write(2'd1, 8'h01);
      tick(); tick();
      chk("rst.notake", intr_sync, 1'b0);
      chk_rd("rst.pend.post", 2'd2, 8'h00);
      src_intr = 8'h01; tick();                chk("rst.edge.set", intr_sync, 1'b0);
      src_intr = 8'h00; tick();                chk_out("rst.edge.take", 1, 1, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
